// File: rtl/perm_pkg.sv
// Shared types and helpers for the Keccak permutation state loader/drainer.
// Lanes are walked y-fastest: (0,0),(0,1)..(0,4),(1,0)..(4,4).
package perm_pkg;

  localparam int LANE_BITS = 64;
  localparam int NLANES    = 25;
  localparam int COORD_MAX = 4;

  typedef logic [LANE_BITS-1:0] lane_t;
  typedef logic [2:0]           coord_t;
  typedef logic [4:0]           lane_idx_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } coord_pair_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_t;

  // Step one lane in stream order: y wraps first, then x; (4,4) wraps to (0,0).
  function automatic coord_pair_t next_coord(input coord_t x, input coord_t y);
    coord_pair_t r;
    if (y == coord_t'(COORD_MAX)) begin
      r.y = '0;
      r.x = (x == coord_t'(COORD_MAX)) ? coord_t'(0) : coord_t'(x + 3'd1);
    end else begin
      r.x = x;
      r.y = coord_t'(y + 3'd1);
    end
    return r;
  endfunction

  // Linear lane index in stream order.
  function automatic lane_idx_t lane_index(input coord_t x, input coord_t y);
    return lane_idx_t'(({2'b00, x} * 5'd5) + {2'b00, y});
  endfunction

endpackage

// File: rtl/perm_lane_cnt.sv
// x/y lane counter walking the state in stream order. Clear wins over advance.
module perm_lane_cnt
  import perm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       advance,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic [4:0] idx
);

  coord_t      x_reg;
  coord_t      y_reg;
  coord_pair_t step;

  assign step = next_coord(x_reg, y_reg);

  // Coordinate register: clear returns to (0,0), advance steps one lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (clear) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (advance) begin
      x_reg <= step.x;
      y_reg <= step.y;
    end
  end

  assign x   = x_reg;
  assign y   = y_reg;
  assign idx = lane_index(x_reg, y_reg);

endmodule

// File: rtl/perm_out_stream.sv
// Drains the final 5x5 permutation state lane by lane onto the
// pushout/stopout/firstout/dout handshake.
// Optional macro PERM_OUT_STREAM_LASTOUT_EN adds a lastout flag on the final lane.
module perm_out_stream
  import perm_pkg::*;
#(
  parameter int LANE_W    = 64,
  parameter int OUT_LANES = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [2:0]        mrx,
  output logic [2:0]        mry,
  input  logic [LANE_W-1:0] mrd,
  output logic              pushout,
  input  logic              stopout,
  output logic              firstout,
`ifdef PERM_OUT_STREAM_LASTOUT_EN
  output logic              lastout,
`endif
  output logic [LANE_W-1:0] dout
);

  localparam lane_idx_t LAST_IDX = lane_idx_t'(OUT_LANES - 1);

  stream_state_t     state_reg, state_next;
  logic [LANE_W-1:0] dout_reg, dout_next;
  logic              push_reg, push_next;
  logic              first_reg, first_next;
  logic              last_reg, last_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              cnt_clear;
  logic              cnt_advance;
  logic [2:0]        cnt_x;
  logic [2:0]        cnt_y;
  logic [4:0]        cnt_idx;
  logic              xfer;

  perm_lane_cnt u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .x       (cnt_x),
    .y       (cnt_y),
    .idx     (cnt_idx)
  );

  // A lane leaves on every edge where it is offered and not back-pressured.
  assign xfer = push_reg && !stopout;

  // Next-state and datapath decisions; the counter always points at the
  // next lane to fetch, so mrd is the lane that follows the one in dout.
  always_comb begin
    state_next  = state_reg;
    dout_next   = dout_reg;
    push_next   = push_reg;
    first_next  = first_reg;
    last_next   = last_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          dout_next   = mrd;
          push_next   = 1'b1;
          first_next  = 1'b1;
          last_next   = (LAST_IDX == lane_idx_t'(0));
          busy_next   = 1'b1;
          cnt_advance = 1'b1;
          state_next  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          if (last_reg) begin
            push_next  = 1'b0;
            first_next = 1'b0;
            last_next  = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            cnt_clear  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            dout_next   = mrd;
            first_next  = 1'b0;
            last_next   = (cnt_idx == LAST_IDX);
            cnt_advance = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any stream without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      dout_reg  <= '0;
      push_reg  <= 1'b0;
      first_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      dout_reg  <= dout_next;
      push_reg  <= push_next;
      first_reg <= first_next;
      last_reg  <= last_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Read address: parked at (0,0) while idle, otherwise the fetch counter.
  always_comb begin
    mrx = 3'd0;
    mry = 3'd0;
    if (state_reg == ST_STREAM) begin
      mrx = cnt_x;
      mry = cnt_y;
    end
  end

  assign dout     = dout_reg;
  assign pushout  = push_reg;
  assign firstout = first_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
`ifdef PERM_OUT_STREAM_LASTOUT_EN
  assign lastout  = push_reg && last_reg;
`endif

endmodule

// File: tb/tb_perm_out_stream.sv
// Directed bench for perm_out_stream: full streams, stalls, ignored starts,
// mid-stream reset and a shortened OUT_LANES=17 instance.
module tb_perm_out_stream;

  typedef struct {
    logic [7:0] lane;
    bit         first;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stopout = 1'b0;
  logic        sel = 1'b0;

  logic        busy_a, done_a, push_a, first_a;
  logic [2:0]  mrx_a, mry_a;
  logic [63:0] mrd_a, dout_a;
  logic        busy_b, done_b, push_b, first_b;
  logic [2:0]  mrx_b, mry_b;
  logic [63:0] mrd_b, dout_b;
  logic        start_a, start_b;

  logic        c_busy, c_done, c_push, c_first;
  logic [2:0]  c_mrx, c_mry;
  logic [63:0] c_dout;
`ifdef PERM_OUT_STREAM_LASTOUT_EN
  logic        last_a, last_b, c_last;
`endif

  int checks = 0;
  int errors = 0;
  vec_t exp_tab [25];

  always #5 clk = ~clk;

  // State memory model: lane (x,y) holds 0xXY.
  assign mrd_a = {56'h0, 1'b0, mrx_a, 1'b0, mry_a};
  assign mrd_b = {56'h0, 1'b0, mrx_b, 1'b0, mry_b};

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  assign c_busy  = sel ? busy_b  : busy_a;
  assign c_done  = sel ? done_b  : done_a;
  assign c_push  = sel ? push_b  : push_a;
  assign c_first = sel ? first_b : first_a;
  assign c_mrx   = sel ? mrx_b   : mrx_a;
  assign c_mry   = sel ? mry_b   : mry_a;
  assign c_dout  = sel ? dout_b  : dout_a;
`ifdef PERM_OUT_STREAM_LASTOUT_EN
  assign c_last  = sel ? last_b  : last_a;
`endif

  perm_out_stream #(.LANE_W(64), .OUT_LANES(25)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .mrx(mrx_a), .mry(mry_a), .mrd(mrd_a), .pushout(push_a),
    .stopout(stopout), .firstout(first_a),
`ifdef PERM_OUT_STREAM_LASTOUT_EN
    .lastout(last_a),
`endif
    .dout(dout_a)
  );

  perm_out_stream #(.LANE_W(64), .OUT_LANES(17)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .mrx(mrx_b), .mry(mry_b), .mrd(mrd_b), .pushout(push_b),
    .stopout(stopout), .firstout(first_b),
`ifdef PERM_OUT_STREAM_LASTOUT_EN
    .lastout(last_b),
`endif
    .dout(dout_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One stream: optional stall on beat stall_idx, extra start on beat
  // restart_idx, or asynchronous reset on beat abort_idx.
  task automatic run_stream(input bit use_b, input int exp_n, input int stall_idx,
                            input int stall_cyc, input int restart_idx, input int abort_idx);
    int beat = 0;
    int stall_left = stall_cyc;
    int cycles = 0;
    bit restarted = 1'b0;
    sel = use_b;
    stopout = 1'b0;
    #0;
    chk("idle_push", {63'h0, c_push}, 64'h0);
    chk("idle_busy", {63'h0, c_busy}, 64'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("latency_push", {63'h0, c_push}, 64'h1);
    chk("start_busy", {63'h0, c_busy}, 64'h1);
    while (beat < exp_n && cycles < 400) begin
      if (beat == abort_idx) begin
        #2 rst = 1'b1;
        #1;
        chk("abort_push", {63'h0, c_push}, 64'h0);
        chk("abort_busy", {63'h0, c_busy}, 64'h0);
        chk("abort_dout", c_dout, 64'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
          chk("abort_no_done", {63'h0, c_done}, 64'h0);
          chk("abort_idle", {63'h0, c_push}, 64'h0);
          tick();
        end
        $display("stream aborted by reset at beat %0d", beat);
        return;
      end
      stopout = (beat == stall_idx) && (stall_left > 0);
      if (stopout) stall_left--;
      start = (beat == restart_idx) && !restarted;
      if (start) restarted = 1'b1;
      chk("pushout", {63'h0, c_push}, 64'h1);
      chk("busy", {63'h0, c_busy}, 64'h1);
      chk("done_low", {63'h0, c_done}, 64'h0);
      chk("dout", c_dout, {56'h0, exp_tab[beat].lane});
      chk("firstout", {63'h0, c_first}, {63'h0, exp_tab[beat].first});
`ifdef PERM_OUT_STREAM_LASTOUT_EN
      chk("lastout", {63'h0, c_last}, {63'h0, (beat == exp_n - 1)});
`endif
      if (stopout) begin
        $display("beat %0d dout=%02h stalled", beat, c_dout[7:0]);
      end else begin
        $display("beat %0d dout=%02h first=%0d", beat, c_dout[7:0], c_first);
        beat++;
      end
      tick();
      cycles++;
    end
    start = 1'b0;
    stopout = 1'b0;
    chk("beat_count", beat, exp_n);
    chk("done_pulse", {63'h0, c_done}, 64'h1);
    chk("end_busy", {63'h0, c_busy}, 64'h0);
    chk("end_push", {63'h0, c_push}, 64'h0);
    chk("end_mrx", {61'h0, c_mrx}, 64'h0);
    chk("end_mry", {61'h0, c_mry}, 64'h0);
    tick();
    chk("done_one_cycle", {63'h0, c_done}, 64'h0);
    chk("no_extra_push", {63'h0, c_push}, 64'h0);
    tick();
    chk("still_idle", {63'h0, c_busy}, 64'h0);
    $display("stream of %0d lanes finished", beat);
  endtask

  initial begin
    exp_tab = '{
      '{8'h00, 1'b1}, '{8'h01, 1'b0}, '{8'h02, 1'b0}, '{8'h03, 1'b0}, '{8'h04, 1'b0},
      '{8'h10, 1'b0}, '{8'h11, 1'b0}, '{8'h12, 1'b0}, '{8'h13, 1'b0}, '{8'h14, 1'b0},
      '{8'h20, 1'b0}, '{8'h21, 1'b0}, '{8'h22, 1'b0}, '{8'h23, 1'b0}, '{8'h24, 1'b0},
      '{8'h30, 1'b0}, '{8'h31, 1'b0}, '{8'h32, 1'b0}, '{8'h33, 1'b0}, '{8'h34, 1'b0},
      '{8'h40, 1'b0}, '{8'h41, 1'b0}, '{8'h42, 1'b0}, '{8'h43, 1'b0}, '{8'h44, 1'b0}
    };
    rst = 1'b1;
    tick();
    chk("rst_push", {63'h0, push_a}, 64'h0);
    chk("rst_first", {63'h0, first_a}, 64'h0);
    chk("rst_busy", {63'h0, busy_a}, 64'h0);
    chk("rst_done", {63'h0, done_a}, 64'h0);
    chk("rst_dout", dout_a, 64'h0);
    chk("rst_mrx", {61'h0, mrx_a}, 64'h0);
    chk("rst_mry", {61'h0, mry_a}, 64'h0);
`ifdef PERM_OUT_STREAM_LASTOUT_EN
    chk("rst_last", {63'h0, last_a}, 64'h0);
`endif
    rst = 1'b0;
    tick();

    run_stream(1'b0, 25, -1, 0, -1, -1);   // plain full stream
    run_stream(1'b0, 25, 2, 3, -1, -1);    // 3-cycle stall on 0x02
    run_stream(1'b0, 25, -1, 0, 7, -1);    // start at 0x12 ignored
    run_stream(1'b0, 25, -1, 0, -1, 10);   // reset at 0x20
    run_stream(1'b0, 25, -1, 0, -1, -1);   // fresh stream after reset
    run_stream(1'b1, 17, -1, 0, 16, -1);   // 17 lanes, start on final beat ignored
    run_stream(1'b0, 25, 24, 2, -1, -1);   // stall on the final lane

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
